// File: rtl/rng_test_pkg.sv
// Shared types and width helpers for the serial RNG stream tester.
// Contents:
//   mode_e   - test select: monobit, runs, block frequency, cumulative sums
//   state_e  - controller states IDLE / COLLECT / EVAL / DONE
//   width helpers - clog2-derived widths of counters, signed sums and the
//                   block-frequency square accumulator
package rng_test_pkg;

    typedef enum logic [1:0] {
        MODE_MONO  = 2'd0,
        MODE_RUNS  = 2'd1,
        MODE_BF    = 2'd2,
        MODE_CUSUM = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EVAL    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Unsigned counter width able to hold the value n_bits itself.
    function automatic int cnt_w(input int n_bits);
        return $clog2(n_bits) + 1;
    endfunction

    // Signed width for S = 2*ones - n_bits and the running sum S_k.
    function automatic int s_w(input int n_bits);
        return $clog2(n_bits) + 2;
    endfunction

    // Width of the position counter inside one block.
    function automatic int blk_w(input int m_blk);
        return $clog2(m_blk);
    endfunction

    // Sum of d^2 is at most (n_bits/m_blk)*m_blk^2 = n_bits*m_blk.
    function automatic int sq_w(input int n_bits, input int m_blk);
        return $clog2(n_bits * m_blk) + 1;
    endfunction

endpackage

// File: rtl/rng_block_sq_accum.sv
// Block-frequency helper: counts ones inside each aligned M_BLK-bit block and,
// on the last bit of a block, adds d^2 (d = 2*c - M_BLK) to a running total.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   clr_i       - clears the block position, block count and total
//   en_i        - consume bit_i this cycle
//   bit_i       - serial bit under test
//   sum_sq_o    - accumulated sum of d^2 (registered)
module rng_block_sq_accum
    import rng_test_pkg::*;
#(
    parameter int N_BITS = 128,
    parameter int M_BLK  = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clr_i,
    input  logic                              en_i,
    input  logic                              bit_i,
    output logic [sq_w(N_BITS, M_BLK)-1:0]    sum_sq_o
);

    localparam int LM = blk_w(M_BLK);
    localparam int DW = LM + 2;
    localparam int QW = sq_w(N_BITS, M_BLK);
    localparam logic [DW-1:0] M_W = DW'(M_BLK);

    logic [LM-1:0] pos_q, pos_d;
    logic [LM:0]   ones_q, ones_d;
    logic [QW-1:0] sum_q, sum_d;
    logic [LM:0]   c_full_s;
    logic [DW-1:0] two_c_s;
    logic [DW-1:0] abs_d_s;
    logic [QW-1:0] sq_s;

    // Next-state for the block counters and the square accumulator.
    always_comb begin
        pos_d    = pos_q;
        ones_d   = ones_q;
        sum_d    = sum_q;
        c_full_s = ones_q + {{LM{1'b0}}, bit_i};
        two_c_s  = {c_full_s, 1'b0};
        // |2c - M| without a signed intermediate.
        if (two_c_s >= M_W) begin
            abs_d_s = two_c_s - M_W;
        end else begin
            abs_d_s = M_W - two_c_s;
        end
        sq_s = QW'(abs_d_s) * QW'(abs_d_s);
        if (clr_i) begin
            pos_d  = {LM{1'b0}};
            ones_d = {(LM+1){1'b0}};
            sum_d  = {QW{1'b0}};
        end else if (en_i) begin
            pos_d = pos_q + LM'(1);
            if (pos_q == {LM{1'b1}}) begin
                ones_d = {(LM+1){1'b0}};
                sum_d  = sum_q + sq_s;
            end else begin
                ones_d = c_full_s;
            end
        end else begin
            pos_d = pos_q;
        end
    end

    // Block counter and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q  <= {LM{1'b0}};
            ones_q <= {(LM+1){1'b0}};
            sum_q  <= {QW{1'b0}};
        end else begin
            pos_q  <= pos_d;
            ones_q <= ones_d;
            sum_q  <= sum_d;
        end
    end

    assign sum_sq_o = sum_q;

endmodule

// File: rtl/rng_stream_tester.sv
// Serial randomness tester: collects N_BITS bits and evaluates one of four
// tests (monobit, runs, block frequency, cumulative sums) on them.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   start, mode        - begin a test in IDLE; mode latched at start
//   epsilon_rsc_dat    - serial bit, consumed when epsilon_vld=1 in COLLECT
//   epsilon_vld        - bit qualifier
//   is_random_rsc_dat  - verdict (1 = pass), held until the next start
//   valid_rsc_dat      - one-cycle verdict strobe (DONE state)
//   busy               - high in COLLECT and EVAL
module rng_stream_tester
    import rng_test_pkg::*;
#(
    parameter int N_BITS       = 128,
    parameter int M_BLK        = 8,
    parameter int MONO_THR     = 29,
    parameter int RUNS_PRE_THR = 45,
    parameter int RUNS_LO      = 49,
    parameter int RUNS_HI      = 80,
    parameter int BF_THR       = 256,
    parameter int CUSUM_THR    = 35
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic       epsilon_rsc_dat,
    input  logic       epsilon_vld,
    output logic       is_random_rsc_dat,
    output logic       valid_rsc_dat,
    output logic       busy
);

    localparam int CW = cnt_w(N_BITS);
    localparam int SW = s_w(N_BITS);
    localparam int QW = sq_w(N_BITS, M_BLK);

    localparam logic [CW-1:0]        LAST_W     = CW'(N_BITS - 1);
    localparam logic [SW-1:0]        N_W        = SW'(N_BITS);
    localparam logic signed [SW-1:0] ONE_S      = SW'(1);
    localparam logic [SW-1:0]        MONO_W     = SW'(MONO_THR);
    localparam logic [SW-1:0]        RUNS_PRE_W = SW'(RUNS_PRE_THR);
    localparam logic [CW-1:0]        RUNS_LO_W  = CW'(RUNS_LO);
    localparam logic [CW-1:0]        RUNS_HI_W  = CW'(RUNS_HI);
    localparam logic [QW-1:0]        BF_W       = QW'(BF_THR);
    localparam logic [SW-1:0]        CUSUM_W    = SW'(CUSUM_THR);

    state_e                 state_q, state_d;
    mode_e                  mode_q, mode_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [CW-1:0]          ones_q, ones_d;
    logic                   prev_q, prev_d;
    logic [CW-1:0]          trans_q, trans_d;
    logic signed [SW-1:0]   sum_q, sum_d;
    logic [SW-1:0]          max_abs_q, max_abs_d;
    logic                   verdict_q, verdict_d;
    logic                   valid_q, busy_q;

    logic                   accept_s, consume_s;
    logic signed [SW-1:0]   step_sum_s;
    logic [SW-1:0]          step_abs_s;
    logic signed [SW-1:0]   s_s;
    logic [SW-1:0]          abs_s_s;
    logic [CW-1:0]          runs_s;
    logic [QW-1:0]          sum_sq_s;
    logic                   pass_s;

    rng_block_sq_accum #(
        .N_BITS (N_BITS),
        .M_BLK  (M_BLK)
    ) u_block_sq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (accept_s),
        .en_i     (consume_s),
        .bit_i    (epsilon_rsc_dat),
        .sum_sq_o (sum_sq_s)
    );

    // Verdict from the final accumulator contents for the latched mode.
    always_comb begin
        // Modular arithmetic is fine: the true S lies in [-N, N].
        s_s     = $signed({ones_q, 1'b0} - N_W);
        abs_s_s = s_s[SW-1] ? -s_s : s_s;
        runs_s  = trans_q + CW'(1);
        case (mode_q)
            MODE_MONO:  pass_s = (abs_s_s <= MONO_W);
            MODE_RUNS:  pass_s = (abs_s_s < RUNS_PRE_W) &&
                                 (runs_s >= RUNS_LO_W) && (runs_s <= RUNS_HI_W);
            MODE_BF:    pass_s = (sum_sq_s <= BF_W);
            MODE_CUSUM: pass_s = (max_abs_q <= CUSUM_W);
            default:    pass_s = 1'b0;
        endcase
    end

    // Controller next-state and shared accumulator updates.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        ones_d     = ones_q;
        prev_d     = prev_q;
        trans_d    = trans_q;
        sum_d      = sum_q;
        max_abs_d  = max_abs_q;
        verdict_d  = verdict_q;
        accept_s   = 1'b0;
        consume_s  = 1'b0;
        step_sum_s = epsilon_rsc_dat ? (sum_q + ONE_S) : (sum_q - ONE_S);
        step_abs_s = step_sum_s[SW-1] ? -step_sum_s : step_sum_s;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept_s  = 1'b1;
                    state_d   = ST_COLLECT;
                    mode_d    = mode_e'(mode);
                    cnt_d     = {CW{1'b0}};
                    ones_d    = {CW{1'b0}};
                    prev_d    = 1'b0;
                    trans_d   = {CW{1'b0}};
                    sum_d     = {SW{1'b0}};
                    max_abs_d = {SW{1'b0}};
                    verdict_d = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (epsilon_vld) begin
                    consume_s = 1'b1;
                    cnt_d     = cnt_q + CW'(1);
                    ones_d    = ones_q + {{(CW-1){1'b0}}, epsilon_rsc_dat};
                    prev_d    = epsilon_rsc_dat;
                    sum_d     = step_sum_s;
                    // The very first bit has no predecessor to transition from.
                    if ((cnt_q != {CW{1'b0}}) && (epsilon_rsc_dat != prev_q)) begin
                        trans_d = trans_q + CW'(1);
                    end else begin
                        trans_d = trans_q;
                    end
                    if (step_abs_s > max_abs_q) begin
                        max_abs_d = step_abs_s;
                    end else begin
                        max_abs_d = max_abs_q;
                    end
                    if (cnt_q == LAST_W) begin
                        state_d = ST_EVAL;
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end else begin
                    state_d = ST_COLLECT;
                end
            end
            ST_EVAL: begin
                verdict_d = pass_s;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, accumulators and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            mode_q    <= MODE_MONO;
            cnt_q     <= {CW{1'b0}};
            ones_q    <= {CW{1'b0}};
            prev_q    <= 1'b0;
            trans_q   <= {CW{1'b0}};
            sum_q     <= {SW{1'b0}};
            max_abs_q <= {SW{1'b0}};
            verdict_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            cnt_q     <= cnt_d;
            ones_q    <= ones_d;
            prev_q    <= prev_d;
            trans_q   <= trans_d;
            sum_q     <= sum_d;
            max_abs_q <= max_abs_d;
            verdict_q <= verdict_d;
            valid_q   <= (state_d == ST_DONE);
            busy_q    <= (state_d == ST_COLLECT) || (state_d == ST_EVAL);
        end
    end

    assign is_random_rsc_dat = verdict_q;
    assign valid_rsc_dat     = valid_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_rng_stream_tester.sv
// Scoreboard bench for rng_stream_tester with default parameters (N_BITS=128).
// Each directed run pushes its hand-computed verdict and the cycle on which
// the strobe must appear; a monitor on the falling edge pops and compares.
module tb_rng_stream_tester;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic       eps = 1'b0;
    logic       eps_vld = 1'b0;
    logic       is_random;
    logic       valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic  verdict;
        int    due;
        string nm;
    } exp_t;

    exp_t exp_q[$];

    rng_stream_tester dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .mode              (mode),
        .epsilon_rsc_dat   (eps),
        .epsilon_vld       (eps_vld),
        .is_random_rsc_dat (is_random),
        .valid_rsc_dat     (valid),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every strobe must match the oldest expected verdict and cycle.
    always @(negedge clk) begin
        exp_t e;
        if (valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_valid: strobe at cycle %0d with no verdict pending", cyc);
            end else begin
                e = exp_q.pop_front();
                if ((is_random !== e.verdict) || (cyc != e.due)) begin
                    n_bad++;
                    $display("FAIL %s: got verdict %0b at cycle %0d, expected %0b at cycle %0d",
                             e.nm, is_random, cyc, e.verdict, e.due);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // 'k' leading ones, then 0101... ; max |S_k| is exactly k.
    function automatic logic [127:0] make_cus(input int k);
        logic [127:0] p;
        for (int i = 0; i < 128; i++) begin
            p[127-i] = (i < k) ? 1'b1 : (((i - k) % 2) == 1);
        end
        return p;
    endfunction

    // One full test: start, 128 bits MSB first, expected verdict queued.
    task automatic run(input string nm, input logic [1:0] m, input logic [127:0] pat,
                       input logic ex, input bit gaps, input bit poke);
        @(posedge clk); #1;
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        mode  = ~m;
        check({nm, "_busy"}, {31'd0, busy}, 32'd1);
        check({nm, "_clr"}, {31'd0, is_random}, 32'd0);
        for (int i = 0; i < 128; i++) begin
            if (gaps && ($urandom_range(0, 1) == 1)) begin
                eps_vld = 1'b0;
                eps     = ~pat[127-i];
                @(posedge clk); #1;
            end
            eps_vld = 1'b1;
            eps     = pat[127-i];
            start   = poke && ((i % 16) == 5);
            @(posedge clk); #1;
        end
        eps_vld = 1'b0;
        start   = 1'b0;
        exp_q.push_back('{ex, cyc + 1, nm});
        @(posedge clk); #1;
        // Now in DONE; a start here must be dropped.
        start = poke;
        @(posedge clk); #1;
        start = 1'b0;
        check({nm, "_seen"}, exp_q.size(), 32'd0);
        check({nm, "_hold"}, {31'd0, is_random}, {31'd0, ex});
        @(posedge clk); #1;
        check({nm, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic [127:0] all1, alt, p0f, pcc, half, bf256, bf320, on78, on79;
        all1  = {128{1'b1}};
        alt   = {16{8'hAA}};
        p0f   = {16{8'h0F}};
        pcc   = {16{8'hCC}};
        half  = {{64{1'b1}}, {64{1'b0}}};
        bf256 = {8'hFF, 8'hFF, 8'h00, 8'h00, {12{8'h0F}}};
        bf320 = {8'hFF, 8'hFF, 8'h00, 8'h00, 8'hFF, {11{8'h0F}}};
        on78  = {{78{1'b1}}, {50{1'b0}}};
        on79  = {{79{1'b1}}, {49{1'b0}}};

        #3;
        check("rst_verdict", {31'd0, is_random}, 32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        run("mono_all1",  2'd0, all1, 1'b0, 1'b0, 1'b0);
        run("mono_alt",   2'd0, alt,  1'b1, 1'b0, 1'b0);
        run("mono_s28",   2'd0, on78, 1'b1, 1'b0, 1'b0);
        run("mono_s30",   2'd0, on79, 1'b0, 1'b0, 1'b0);
        run("runs_alt",   2'd1, alt,  1'b0, 1'b0, 1'b0);
        run("runs_0f",    2'd1, p0f,  1'b0, 1'b0, 1'b0);
        run("runs_cc",    2'd1, pcc,  1'b1, 1'b0, 1'b0);
        run("runs_all1",  2'd1, all1, 1'b0, 1'b0, 1'b0);
        run("bf_0f",      2'd2, p0f,  1'b1, 1'b0, 1'b0);
        run("bf_256",     2'd2, bf256, 1'b1, 1'b0, 1'b0);
        run("bf_320",     2'd2, bf320, 1'b0, 1'b0, 1'b0);
        run("bf_all1",    2'd2, all1, 1'b0, 1'b0, 1'b0);
        run("cus_half",   2'd3, half, 1'b0, 1'b0, 1'b0);
        run("cus_35",     2'd3, make_cus(35), 1'b1, 1'b0, 1'b0);
        run("cus_36",     2'd3, make_cus(36), 1'b0, 1'b0, 1'b0);
        run("mono_gaps",  2'd0, alt,  1'b1, 1'b1, 1'b0);
        run("mono_gaps1", 2'd0, all1, 1'b0, 1'b1, 1'b0);
        run("cus_poke",   2'd3, alt,  1'b1, 1'b0, 1'b1);

        // Reset in the middle of collection after a passing verdict.
        @(posedge clk); #1;
        start = 1'b1;
        mode  = 2'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 60; i++) begin
            eps_vld = 1'b1;
            eps     = 1'b1;
            @(posedge clk); #1;
        end
        eps_vld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_verdict", {31'd0, is_random}, 32'd0);
        check("midrst_valid", {31'd0, valid}, 32'd0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("midrst_idle", {31'd0, busy}, 32'd0);
        check("midrst_noverdict", exp_q.size(), 32'd0);

        run("after_rst",  2'd0, alt,  1'b1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rng_stream_tester.md
RNG_STREAM_TESTER -- requirements
Module: rng_stream_tester

Interface
REQ-001 SHALL have parameter N_BITS, default 128: sequence length; multiple of M_BLK, 16 to 1024.
REQ-002 SHALL have parameter M_BLK, default 8: block size for block-frequency mode; power of two, at least 4.
REQ-003 SHALL have parameter MONO_THR, default 29: monobit pass limit on |S|.
REQ-004 SHALL have parameters RUNS_PRE_THR, RUNS_LO and RUNS_HI, defaults 45, 49 and 80: runs-test prerequisite limit on |S|, and the inclusive pass window.
REQ-005 SHALL have parameter BF_THR, default 256: block-frequency pass limit on the sum of squares.
REQ-006 SHALL have parameter CUSUM_THR, default 35: cumulative-sums pass limit on max |S_k|.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; rising edge.
REQ-008 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port start, input, 1 bit: begins a test when the block is idle.
REQ-010 SHALL have port mode, input, 2 bits: test select; 0 monobit, 1 runs, 2 block-frequency, 3 cumulative sums.
REQ-011 SHALL have port epsilon_rsc_dat, input, 1 bit: serial bit under test.
REQ-012 SHALL have port epsilon_vld, input, 1 bit: epsilon_rsc_dat is consumed on cycles where this is 1.
REQ-013 SHALL have port is_random_rsc_dat, output, 1 bit: verdict; 1 means pass.
REQ-014 SHALL have port valid_rsc_dat, output, 1 bit: verdict strobe, high for one cycle.
REQ-015 SHALL have port busy, output, 1 bit: high in COLLECT and EVAL.

Function
REQ-016 SHALL implement FSM states IDLE, COLLECT, EVAL and DONE.
REQ-017 SHALL leave IDLE for COLLECT when start=1, latching mode and clearing all accumulators in that same cycle.
REQ-018 SHALL ignore start while in COLLECT or EVAL; mode changes after the latch SHALL have no effect.
REQ-019 SHALL, in COLLECT, consume one bit per cycle with epsilon_vld=1; cycles with epsilon_vld=0 SHALL leave all state unchanged.
REQ-020 SHALL go from COLLECT to EVAL on the cycle that consumes bit N_BITS, then to DONE after one EVAL cycle, then to IDLE after one DONE cycle.
REQ-021 SHALL drive valid_rsc_dat=1 only in DONE, so the verdict appears exactly 2 cycles after the last bit is consumed.
REQ-022 SHALL hold is_random_rsc_dat from DONE until the next start, then clear it to 0.
REQ-023 SHALL define S = 2*ones - N_BITS, evaluated with a signed width of clog2(N_BITS)+2.
REQ-024 SHALL, in mode 0, pass iff |S| <= MONO_THR.
REQ-025 SHALL, in mode 1, count runs as 1 plus the number of adjacent-bit transitions, and pass iff |S| < RUNS_PRE_THR and RUNS_LO <= runs <= RUNS_HI.
REQ-026 SHALL, in mode 2, compute d = 2*c - M_BLK for each aligned M_BLK block (c = ones in the block), and pass iff the sum of d^2 <= BF_THR.
REQ-027 SHALL size the mode-2 accumulator so it cannot saturate: (N_BITS/M_BLK)*M_BLK^2 must fit.
REQ-028 SHALL, in mode 3, track the running sum S_k (+1 per one, -1 per zero) and pass iff max |S_k| <= CUSUM_THR over all k.
REQ-029 SHALL treat a start arriving in the DONE cycle as ignored; it is accepted only once back in IDLE.
REQ-030 SHALL NOT use epsilon_vld while in IDLE, EVAL or DONE.

Reset
REQ-031 SHALL, on rst_n=0 (asynchronous, any state including mid-COLLECT), force the FSM to IDLE and clear all counters.
REQ-032 SHALL drive is_random_rsc_dat=0, valid_rsc_dat=0 and busy=0 while reset is asserted and until the first verdict after reset.

Structure
REQ-033 SHALL place the mode enum, the FSM state enum and the clog2-derived width constants in package rng_test_pkg.
REQ-034 SHALL instantiate one sub-module, rng_block_sq_accum, which counts ones per block and accumulates d^2 for mode 2.
REQ-035 SHALL share the ones counter, previous-bit register and running-sum register across all modes.

Verification (defaults, N_BITS=128)
REQ-036 SHALL check: mode 0, 128 ones -> valid_rsc_dat pulse 2 cycles after the last bit, is_random_rsc_dat=0.
REQ-037 SHALL check: mode 0, alternating 1010 pattern -> S=0, is_random_rsc_dat=1.
REQ-038 SHALL check: mode 1, alternating 1010 pattern -> runs=128 > 80, is_random_rsc_dat=0; mode 1 with blocks of 0x0F repeating (MSB first) -> runs=32 < 49, fail.
REQ-039 SHALL check: mode 2, byte 0x0F repeated 16 times -> sum 0, pass; mode 3 with 64 ones then 64 zeros -> max |S_k|=64 > 35, fail.
REQ-040 SHALL check: epsilon_vld low 50% random gaps during mode 0 -> verdict identical to the gap-free run, and valid_rsc_dat only after the 128th consumed bit.
REQ-041 SHALL check: rst_n pulsed low after 60 bits -> busy=0 immediately; start pulsed during COLLECT -> ignored and no early verdict.
